// File: rtl/ascon_sbox_scheduler_if.sv
// rtl/ascon_sbox_scheduler_if.sv - state in/out handshake and S-box LUT port bundle
interface ascon_sbox_scheduler_if #(
    parameter int LANES = 16
);
    logic                        in_valid_i;
    logic                        in_ready_o;
    logic [4:0][63:0]            state_i;
    logic                        out_valid_o;
    logic                        out_ready_i;
    logic [4:0][63:0]            state_o;
    logic                        lut_req_o;
    logic [LANES-1:0][4:0]       lut_addr_o;
    logic [LANES-1:0][4:0]       lut_data_i;

    modport slave (
        input  in_valid_i, state_i, out_ready_i, lut_data_i,
        output in_ready_o, out_valid_o, state_o, lut_req_o, lut_addr_o
    );

    modport master (
        output in_valid_i, state_i, out_ready_i, lut_data_i,
        input  in_ready_o, out_valid_o, state_o, lut_req_o, lut_addr_o
    );
endinterface

// File: rtl/ascon_sbox_scheduler.sv
// rtl/ascon_sbox_scheduler.sv - ASCON S-box layer via LANES external LUT lookups per cycle
module ascon_sbox_scheduler #(
    parameter int LANES = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    ascon_sbox_scheduler_if.slave     bus,
    output logic                      busy_o
);
    localparam int NB = 64 / LANES;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BW-1:0] LAST_B = BW'(NB - 1);

    typedef enum logic [1:0] {IDLE, LOOKUP, DONE} fsm_e;

    fsm_e             state_q, state_d;
    logic [BW-1:0]    b_q, b_d;
    logic [4:0][63:0] src_q, src_d;
    logic [4:0][63:0] res_q, res_d;
    logic [5:0]       col;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            b_q     <= '0;
            src_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            src_q   <= src_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        b_d             = b_q;
        src_d           = src_q;
        res_d           = res_q;
        col             = '0;
        bus.in_ready_o  = 1'b0;
        bus.out_valid_o = 1'b0;
        bus.lut_req_o   = 1'b0;
        bus.lut_addr_o  = '0;

        case (state_q)
            IDLE: begin
                bus.in_ready_o = 1'b1;
                if (bus.in_valid_i) begin
                    src_d   = bus.state_i;
                    b_d     = '0;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                bus.lut_req_o = 1'b1;
                // Batch b covers columns b*LANES .. b*LANES+LANES-1; x0/y0 sit in the MSB
                for (int k = 0; k < LANES; k++) begin
                    col = 6'(int'(b_q) * LANES + k);
                    bus.lut_addr_o[k] = {src_q[0][col], src_q[1][col], src_q[2][col],
                                         src_q[3][col], src_q[4][col]};
                    {res_d[0][col], res_d[1][col], res_d[2][col],
                     res_d[3][col], res_d[4][col]} = bus.lut_data_i[k];
                end
                if (b_q == LAST_B) begin
                    b_d     = '0;
                    state_d = DONE;
                end else begin
                    b_d = b_q + 1'b1;
                end
            end
            DONE: begin
                bus.out_valid_o = 1'b1;
                if (bus.out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over any handshake in the same cycle and captures nothing
        if (clear_i) begin
            state_d = IDLE;
            b_d     = '0;
            src_d   = src_q;
            res_d   = res_q;
        end
    end

    assign bus.state_o = res_q;
    assign busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_ascon_sbox_scheduler.sv
// tb/tb_ascon_sbox_scheduler.sv - directed bench for ascon_sbox_scheduler at LANES 16/1/4/64
module tb_ascon_sbox_scheduler;
    typedef logic [4:0][63:0] st_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    st_t  state_in = '0;

    logic [3:0] in_ready, out_valid, lut_req, busy, addr_1f, addr_zero;
    st_t        state_out [4];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    function automatic logic [4:0] sbox(input logic [4:0] a);
        case (a)
            5'h00: sbox = 5'h04; 5'h01: sbox = 5'h0b; 5'h02: sbox = 5'h1f; 5'h03: sbox = 5'h14;
            5'h04: sbox = 5'h1a; 5'h05: sbox = 5'h15; 5'h06: sbox = 5'h09; 5'h07: sbox = 5'h02;
            5'h08: sbox = 5'h1b; 5'h09: sbox = 5'h05; 5'h0a: sbox = 5'h08; 5'h0b: sbox = 5'h12;
            5'h0c: sbox = 5'h1d; 5'h0d: sbox = 5'h03; 5'h0e: sbox = 5'h06; 5'h0f: sbox = 5'h1c;
            5'h10: sbox = 5'h1e; 5'h11: sbox = 5'h13; 5'h12: sbox = 5'h07; 5'h13: sbox = 5'h0e;
            5'h14: sbox = 5'h00; 5'h15: sbox = 5'h0d; 5'h16: sbox = 5'h11; 5'h17: sbox = 5'h18;
            5'h18: sbox = 5'h10; 5'h19: sbox = 5'h0c; 5'h1a: sbox = 5'h01; 5'h1b: sbox = 5'h19;
            5'h1c: sbox = 5'h16; 5'h1d: sbox = 5'h0a; 5'h1e: sbox = 5'h0f; default: sbox = 5'h17;
        endcase
    endfunction

    function automatic st_t model(input st_t x);
        logic [4:0] s;
        model = '0;
        for (int c = 0; c < 64; c++) begin
            s = sbox({x[0][c], x[1][c], x[2][c], x[3][c], x[4][c]});
            model[0][c] = s[4]; model[1][c] = s[3]; model[2][c] = s[2];
            model[3][c] = s[1]; model[4][c] = s[0];
        end
    endfunction

    function automatic st_t mk(input logic [63:0] a, b, c, d, e);
        mk[0] = a; mk[1] = b; mk[2] = c; mk[3] = d; mk[4] = e;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int L = (g == 0) ? 16 : (g == 1) ? 1 : (g == 2) ? 4 : 64;
        ascon_sbox_scheduler_if #(.LANES(L)) bus ();

        assign bus.in_valid_i  = in_valid;
        assign bus.state_i     = state_in;
        assign bus.out_ready_i = out_ready;

        always_comb begin
            bus.lut_data_i = '0;
            for (int k = 0; k < L; k++) bus.lut_data_i[k] = sbox(bus.lut_addr_o[k]);
        end

        assign in_ready[g]  = bus.in_ready_o;
        assign out_valid[g] = bus.out_valid_o;
        assign lut_req[g]   = bus.lut_req_o;
        assign state_out[g] = bus.state_o;
        assign addr_1f[g]   = (bus.lut_addr_o == {L{5'h1f}});
        assign addr_zero[g] = (bus.lut_addr_o == '0);

        ascon_sbox_scheduler #(.LANES(L)) dut (
            .clk_i   (clk),
            .rst_i   (rst),
            .clear_i (clear),
            .bus     (bus),
            .busy_o  (busy[g])
        );
    end

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input st_t st, input int hold, output st_t got,
                           output int lat, output int reqs, output int n1f);
        got = '0; lat = 0; reqs = 0; n1f = 0;
        out_ready = (hold == 0);
        state_in  = st;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        while (!out_valid[0] && lat < 200) begin
            if (lut_req[0]) reqs++;
            if (lut_req[0] && addr_1f[0]) n1f++;
            tick();
            lat++;
        end
        check("valid_seen", out_valid[0], 1);
        got = state_out[0];
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", out_valid[0], 1);
            check("hold_stable", state_out[0], got);
            check("hold_in_ready", in_ready[0], 0);
        end
        out_ready = 1'b1;
        tick();
        check("valid_drop", out_valid[0], 0);
        check("idle_addr_zero", addr_zero[0], 1);
    endtask

    st_t ones, rnd1, rnd2, rnd3, got, exp0, exp1;
    int  lat, reqs, n1f, stray;
    int  sw_reqs [4];
    st_t sw_res [4];

    initial begin
        ones = {5{64'hffff_ffff_ffff_ffff}};
        rnd1 = mk(64'h0123456789abcdef, 64'hfedcba9876543210, 64'hdeadbeefcafef00d,
                  64'h0f0f0f0f33333333, 64'h5555aaaa5555aaaa);
        rnd2 = mk(64'h8000000000000001, 64'h7fffffffffffffe0, 64'h13579bdf2468ace0,
                  64'hc3c3c3c3a5a5a5a5, 64'h00ff00ff0ff00ff0);
        rnd3 = mk(64'h243f6a8885a308d3, 64'h13198a2e03707344, 64'ha4093822299f31d0,
                  64'h082efa98ec4e6c89, 64'h452821e638d01377);
        exp0 = mk(64'h0, 64'h0, 64'hffff_ffff_ffff_ffff, 64'h0, 64'h0);
        exp1 = mk(64'hffff_ffff_ffff_ffff, 64'h0, 64'hffff_ffff_ffff_ffff,
                  64'hffff_ffff_ffff_ffff, 64'hffff_ffff_ffff_ffff);

        // Asynchronous reset before the first clock edge
        #1 rst = 1'b1;
        #2;
        check("rst_in_ready", in_ready, 4'hf);
        check("rst_out_valid", out_valid, 0);
        check("rst_lut_req", lut_req, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", addr_zero, 4'hf);
        check("rst_state_o", state_out[0], 0);
        tick();
        tick();
        rst = 1'b0;

        run_one('0, 0, got, lat, reqs, n1f);
        check("zero_latency", lat, 4);
        check("zero_reqs", reqs, 4);
        check("zero_result", got, exp0);

        run_one(ones, 0, got, lat, reqs, n1f);
        check("ones_addr_1f", n1f, 4);
        check("ones_result", got, exp1);

        run_one(rnd1, 10, got, lat, reqs, n1f);
        check("rnd1_latency", lat, 4);
        check("rnd1_result", got, model(rnd1));

        // Abort in the second LOOKUP cycle
        state_in = rnd2;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("clr_in_lookup", lut_req[0], 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_in_ready", in_ready[0], 1);
        check("clr_busy", busy[0], 0);
        check("clr_lut_req", lut_req[0], 0);
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid[0]) stray++;
            tick();
        end
        check("clr_no_valid", stray, 0);

        clear    = 1'b1;
        in_valid = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr_beats_valid", busy[0], 0);

        run_one(rnd2, 0, got, lat, reqs, n1f);
        check("post_clr_result", got, model(rnd2));

        // Asynchronous reset between edges while in LOOKUP
        state_in = rnd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        check("arst_lut_req", lut_req[0], 0);
        check("arst_busy", busy[0], 0);
        check("arst_in_ready", in_ready[0], 1);
        check("arst_addr", addr_zero[0], 1);
        check("arst_state_o", state_out[0], 0);
        #1 rst = 1'b0;
        #1;

        run_one(rnd3, 0, got, lat, reqs, n1f);
        check("b2b_a_latency", lat, 4);
        check("b2b_a_result", got, model(rnd3));
        run_one(rnd1, 0, got, lat, reqs, n1f);
        check("b2b_b_latency", lat, 4);
        check("b2b_b_result", got, model(rnd1));

        // Same state through all lane widths
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int g = 0; g < 4; g++) begin
            sw_reqs[g] = 0;
            sw_res[g]  = '0;
        end
        out_ready = 1'b1;
        state_in  = rnd2;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int t = 0; t < 80; t++) begin
            for (int g = 0; g < 4; g++) begin
                if (lut_req[g]) sw_reqs[g]++;
                if (out_valid[g]) sw_res[g] = state_out[g];
            end
            tick();
        end
        check("sweep16_reqs", sw_reqs[0], 4);
        check("sweep1_reqs", sw_reqs[1], 64);
        check("sweep4_reqs", sw_reqs[2], 16);
        check("sweep64_reqs", sw_reqs[3], 1);
        check("sweep16_result", sw_res[0], model(rnd2));
        check("sweep1_result", sw_res[1], model(rnd2));
        check("sweep4_result", sw_res[2], model(rnd2));
        check("sweep64_result", sw_res[3], model(rnd2));
        check("sweep_all_idle", in_ready, 4'hf);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ascon_sbox_scheduler.md
ASCON_SBOX_SCHEDULER -- requirements
Module: ascon_sbox_scheduler

Interface
REQ-001 Parameter LANES, default 16: number of parallel LUT lookups issued per cycle; SHALL be one of 1, 2, 4, 8, 16, 32, 64.
REQ-002 Derived constant NB = 64/LANES: number of lookup batches per state.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset; asynchronous and active-high.
REQ-005 clear_i  input  1  synchronous abort; discards the operation in progress.
REQ-006 in_valid_i  input  1  a 320-bit state is offered on state_i.
REQ-007 in_ready_o  output  1  the block can accept a state.
REQ-008 state_i  input  [4:0][63:0]  ASCON lanes x0..x4; bit j of each lane forms column j.
REQ-009 lut_req_o  output  1  high while addresses on lut_addr_o are valid.
REQ-010 lut_addr_o  output  [LANES-1:0][4:0]  S-box LUT addresses.
REQ-011 lut_data_i  input  [LANES-1:0][4:0]  LUT results; combinational, same cycle as the address.
REQ-012 out_valid_o  output  1  substituted state is available on state_o.
REQ-013 out_ready_i  input  1  the consumer accepts state_o.
REQ-014 state_o  output  [4:0][63:0]  substituted lanes y0..y4.
REQ-015 busy_o  output  1  high in LOOKUP and DONE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, LOOKUP and DONE.
REQ-017 IDLE: in_ready_o=1; when in_valid_i=1, the block SHALL capture state_i into the source register, clear the batch counter b to 0, and move to LOOKUP.
REQ-018 LOOKUP: in_ready_o=0 and lut_req_o=1; for k in 0..LANES-1, with column c=b*LANES+k, the block SHALL drive lut_addr_o[k]={x0[c],x1[c],x2[c],x3[c],x4[c]}, where x0 is the MSB.
REQ-019 LOOKUP: on the same edge, the block SHALL write lut_data_i[k] into the result register as {y0[c],y1[c],y2[c],y3[c],y4[c]} (y0 = bit 4).
REQ-020 Counter b SHALL be ceil(log2(NB)) bits wide, minimum 1, and increment once per LOOKUP cycle; when b=NB-1 the block SHALL move to DONE and b SHALL wrap to 0.
REQ-021 DONE: out_valid_o=1 and state_o=result register; state_o SHALL remain stable until the handshake completes.
REQ-022 DONE: when out_ready_i=1, the block SHALL move to IDLE; in_ready_o SHALL stay 0 in DONE, so there is no same-cycle accept-and-restart.
REQ-023 Latency: a state accepted at edge T SHALL see out_valid_o=1 after edge T+NB; for LANES=16 that is 4 LOOKUP cycles, first valid cycle after edge T+4.
REQ-024 Outside LOOKUP, lut_addr_o SHALL be all zeros and lut_req_o SHALL be 0.
REQ-025 clear_i=1 in any state SHALL force IDLE and b=0 at the next edge and drop out_valid_o; the result register content SHALL be don't-care.
REQ-026 clear_i SHALL take priority over in_valid_i and out_ready_i in the same cycle; clear in IDLE together with in_valid_i SHALL capture nothing.
REQ-027 in_valid_i outside IDLE SHALL be ignored.
REQ-028 out_ready_i outside DONE SHALL be ignored.
REQ-029 Changes of lut_data_i outside LOOKUP SHALL have no effect; this permits LUT reconfiguration over the register bus between operations.
REQ-030 The block SHALL not check LUT contents; it is a pure scheduler.

Reset
REQ-031 While rst_i=1, regardless of clk_i, the block SHALL be in IDLE with b=0, in_ready_o=1, out_valid_o=0, lut_req_o=0, busy_o=0, lut_addr_o=0, and source and result registers all zero.
REQ-032 If rst_i asserts mid-LOOKUP or in DONE, the operation SHALL be lost; after release the block SHALL accept a new state on the first cycle.

Verification (LUT model loaded with the ASCON table: S(0x00)=0x04, S(0x1F)=0x17)
REQ-033 Zero state, LANES=16, out_ready_i=1 -> lut_req_o high exactly 4 cycles; state_o: y2=all ones, y0/y1/y3/y4=0; out_valid_o is high 1 cycle.
REQ-034 All-ones state -> all addresses 0x1F; state_o: y0=y2=y3=y4=all ones, y1=0.
REQ-035 Random state with out_ready_i held low for 10 cycles -> out_valid_o held and state_o stable; in_ready_o=0 throughout; matches the software S-box model.
REQ-036 clear_i pulse in the 2nd LOOKUP cycle -> IDLE next cycle, no out_valid_o; the next state completes correctly.
REQ-037 rst_i asserted asynchronously mid-LOOKUP (between edges) -> outputs take reset values immediately; after release, back-to-back states are each processed in NB+1 cycles.
REQ-038 Sweep LANES = 1, 4, 64 -> LOOKUP lasts 64, 16 and 1 cycles respectively; results are identical.
